// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - parametrised pixel word FIFO with count, thresholds and sticky errors
// Build option: define PIXEL_FIFO_SHOWAHEAD_EN for show-ahead (first-word-fall-through) reads;
// by default rd_data is registered and announced by a one-cycle rd_valid strobe.
module pixel_fifo #(
  parameter int WIDTH      = 24,
  parameter int DEPTH_LOG2 = 4,
  parameter int THRESH     = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  wr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  err_clr
);

  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_wptr;
  logic [CW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic             w_wr_reject;
  logic             w_rd_reject;
  logic [CW-1:0]    w_count_next;

  // Status flags come straight from the registered occupancy so wr never reaches an output.
  assign w_full      = (r_count == DEPTH_C);
  assign w_empty     = (r_count == '0);
  // A full FIFO can still take a write when a read frees a slot on the same edge.
  assign w_rd_acc    = rd & ~w_empty & ~flush;
  assign w_wr_acc    = wr & (~w_full | w_rd_acc) & ~flush;
  assign w_wr_reject = wr & ~w_wr_acc & ~flush;
  assign w_rd_reject = rd & w_empty & ~flush;
  assign w_count_next = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);

  assign full        = w_full;
  assign empty       = w_empty;
  assign almost_full = (r_count >= THRESH_C);
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;

  // Storage array is deliberately unreset; only accepted writes land in it.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[DEPTH_LOG2-1:0]] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap modulo 2*DEPTH and flush rewinds everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_next;
    end
  end

  // Sticky error flags; a new error on the same edge as err_clr keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_reject)  r_overflow <= 1'b1;
      else if (err_clr) r_overflow <= 1'b0;
      if (w_rd_reject)  r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
    end
  end

`ifdef PIXEL_FIFO_SHOWAHEAD_EN
  // Head entry is presented without a request; its value is meaningless while empty.
  assign rd_data  = r_mem[r_rptr[DEPTH_LOG2-1:0]];
  assign rd_valid = 1'b0;
`else
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // Registered read port: load the head on an accepted read and strobe rd_valid for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (flush) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rd_data <= r_mem[r_rptr[DEPTH_LOG2-1:0]];
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
`endif

endmodule

// File: tb/tb_pixel_fifo.sv
// tb/tb_pixel_fifo.sv - self-checking bench for pixel_fifo with a queue-based reference model
module tb_pixel_fifo;

  localparam int DEPTH  = 16;
  localparam int THRESH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr = 1'b0;
  logic [23:0] wr_data = '0;
  logic        rd = 1'b0;
  logic [23:0] rd_data;
  logic        rd_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
  logic        err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  pixel_fifo #(.WIDTH(24), .DEPTH_LOG2(4), .THRESH(THRESH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .wr(wr), .wr_data(wr_data),
    .rd(rd), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of words plus the expected read register and flags.
  logic [23:0] q[$];
  logic [23:0] m_data = '0;
  logic        m_valid = 1'b0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else if (flush) begin
      q.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      bit rd_ok, wr_ok, was_empty;
      was_empty = (q.size() == 0);
      rd_ok = rd && !was_empty;
      wr_ok = wr && (q.size() < DEPTH || rd_ok);
      m_valid = rd_ok;
      if (rd_ok) m_data = q.pop_front();
      if (wr_ok) q.push_back(wr_data);
      if (wr && !wr_ok) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
      if (rd && was_empty) m_unf = 1'b1; else if (err_clr) m_unf = 1'b0;
    end
  end

  // Compare every cycle, away from the rising edge.
  always @(negedge clk) begin
    chk("cmp_count", 32'(count), 32'(q.size()));
    chk("cmp_empty", 32'(empty), 32'(q.size() == 0));
    chk("cmp_full", 32'(full), 32'(q.size() == DEPTH));
    chk("cmp_almost_full", 32'(almost_full), 32'(q.size() >= THRESH));
    chk("cmp_overflow", 32'(overflow), 32'(m_ovf));
    chk("cmp_underflow", 32'(underflow), 32'(m_unf));
`ifdef PIXEL_FIFO_SHOWAHEAD_EN
    chk("cmp_rd_valid", 32'(rd_valid), 32'd0);
    if (q.size() > 0) chk("cmp_rd_data", 32'(rd_data), 32'(q[0]));
`else
    chk("cmp_rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("cmp_rd_data", 32'(rd_data), 32'(m_data));
`endif
  end

  task automatic step(input logic w, input logic [23:0] d, input logic r,
                      input logic f, input logic c);
    wr = w; wr_data = d; rd = r; flush = f; err_clr = c;
    @(posedge clk);
    @(negedge clk);
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  // Read one word and check it against a hand-computed value in either read mode.
  task automatic read_expect(input string name, input logic [23:0] exp);
`ifdef PIXEL_FIFO_SHOWAHEAD_EN
    chk(name, 32'(rd_data), 32'(exp));
    step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
`else
    step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    chk(name, 32'(rd_data), 32'(exp));
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
`endif
  endtask

  logic [23:0] vec [3];

  initial begin
    vec[0] = 24'h112233; vec[1] = 24'h445566; vec[2] = 24'h778899;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // Three writes then three reads, in order.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vec[i], 1'b0, 1'b0, 1'b0);
      chk("basic_wr_count", 32'(count), 32'(i + 1));
    end
    for (int i = 0; i < 3; i++) begin
      read_expect("basic_rd_data", vec[i]);
      chk("basic_rd_count", 32'(count), 32'(2 - i));
    end
    chk("basic_end_empty", 32'(empty), 32'd1);

    // Fill to full; watch the almost_full and full thresholds.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 24'h100000 + 24'(i), 1'b0, 1'b0, 1'b0);
      if (i == 6)  chk("fill_af_7", 32'(almost_full), 32'd0);
      if (i == 7)  chk("fill_af_8", 32'(almost_full), 32'd1);
      if (i == 14) chk("fill_full_15", 32'(full), 32'd0);
    end
    chk("fill_full_16", 32'(full), 32'd1);
    step(1'b1, 24'h1FFFFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    step(1'b0, 24'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with simultaneous read and write across pointer wrap.
    for (int i = 0; i < 20; i++) begin
`ifndef PIXEL_FIFO_SHOWAHEAD_EN
      step(1'b1, 24'h200000 + 24'(i), 1'b1, 1'b0, 1'b0);
      if (i == 0) chk("wrap_first_rd", 32'(rd_data), 32'h100000);
`else
      if (i == 0) chk("wrap_first_rd", 32'(rd_data), 32'h100000);
      step(1'b1, 24'h200000 + 24'(i), 1'b1, 1'b0, 1'b0);
`endif
      chk("wrap_count", 32'(count), 32'd16);
    end
    chk("wrap_ovf", 32'(overflow), 32'd0);
    read_expect("wrap_drain_head", 24'h200004);
    for (int i = 0; i < 15; i++) step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);

    // Empty FIFO with simultaneous read and write.
    step(1'b1, 24'hABCDEF, 1'b1, 1'b0, 1'b0);
    chk("empty_rw_unf", 32'(underflow), 32'd1);
    chk("empty_rw_count", 32'(count), 32'd1);
    read_expect("empty_rw_data", 24'hABCDEF);
    // Underflow and err_clr on the same edge: the new error wins.
    step(1'b0, 24'h0, 1'b1, 1'b0, 1'b1);
    chk("unf_set_wins", 32'(underflow), 32'd1);

    // Flush with five entries and a concurrent write.
    for (int i = 0; i < 6; i++) step(1'b1, 24'h300000 + 24'(i), 1'b0, 1'b0, 1'b0);
    read_expect("pre_flush_rd", 24'h300000);
    chk("pre_flush_count", 32'(count), 32'd5);
    step(1'b1, 24'h3FFFFF, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_unf", 32'(underflow), 32'd0);
    chk("flush_rd_valid", 32'(rd_valid), 32'd0);
`ifndef PIXEL_FIFO_SHOWAHEAD_EN
    chk("flush_rd_data_hold", 32'(rd_data), 32'h300000);
`endif

`ifdef PIXEL_FIFO_SHOWAHEAD_EN
    // Show-ahead: the word appears without a read request.
    step(1'b1, 24'h000001, 1'b0, 1'b0, 1'b0);
    chk("sa_head", 32'(rd_data), 32'h000001);
    step(1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    chk("sa_empty", 32'(empty), 32'd1);
`endif

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 4; i++) step(1'b1, 24'h400000 + 24'(i), 1'b0, 1'b0, 1'b0);
    wr = 1'b1; rd = 1'b1; wr_data = 24'h4AAAAA;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    wr = 1'b0; rd = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
